flag_read_arbiter: RTL and testbench
====================================

# flag_read_arbiter

Read side of the write-enabled flag registers used for producer/consumer signalling between processing units. Producers pulse per-flag set lines. This block holds each flag until a single consumer reads it. It offers the index of one pending flag at a time through a valid/ready handshake, choosing among pending flags by round-robin, and clears a flag when it is read (read-and-clear).

## Interface
Parameters:
- NUM_FLAGS, 8: number of flags; legal range 2..64.
- IDX_W, $clog2(NUM_FLAGS): width of the index output.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- setIn  in  NUM_FLAGS  per-flag set pulse from producers; a bit held high for several cycles sets the flag once per cycle it is high.
- rdValid  out  1  an index is on offer.
- rdReady  in  1  consumer accepts the offer.
- rdIdx  out  IDX_W  index of the offered flag.
- anyPending  out  1  OR of all stored flags (registered state, not the selection).
- overflowOut  out  NUM_FLAGS  sticky per-flag overflow; present only with the macro in Configuration.

## Operation
- Each flag is one bit with an asynchronous reset.
  - Next value = setIn[i] | (flag[i] & ~clear[i]).
  - clear[i] is asserted only in the cycle the handshake completes for index i.
  - Set beats clear in the same cycle, so the new event is reported again and never lost.
- FSM has two states:
  - IDLE: rdValid = 0. If any flag is set, the state captures the round-robin winner into rdIdx and moves to OFFER.
  - OFFER: rdValid = 1 and rdIdx is held stable. When rdValid & rdReady, clear[rdIdx] pulses and the state returns to IDLE. Otherwise it stays in OFFER.
- Round-robin selection:
  - A pointer ptr holds the search start.
  - The winner is the first set flag at or after ptr, searching upward modulo NUM_FLAGS.
  - On acceptance, ptr ← rdIdx+1, wrapping from NUM_FLAGS-1 to 0.
- Flags set while an offer is pending do not alter rdIdx or rdValid.
- rdReady asserted while rdValid = 0 is ignored.
- Reset values: rdValid 0, rdIdx 0, anyPending 0, all flags 0, ptr 0, state IDLE, overflowOut 0.
- Reset mid-offer drops the offer and all pending flags immediately, with no clear pulse emitted.

## Timing
- setIn[i] high at edge t → flag set after edge t → anyPending high at t+1 → rdValid high after edge t+1.
- Minimum set-to-offer latency is 2 cycles.
- Handshake at edge t → flag cleared and rdValid low after edge t. The next offer appears no earlier than after edge t+1.
- Maximum throughput is one read per 2 cycles.
- rdIdx and rdValid are registered outputs with no combinational path from rdReady or setIn.

## Configuration
- FLAG_READ_ARBITER_OVERFLOW_EN defined:
  - overflowOut[i] sets when setIn[i] = 1 while flag[i] = 1 and flag[i] is not being cleared that cycle.
  - It is sticky until reset.
- Macro undefined:
  - The overflowOut port is absent.
  - Repeated sets merge silently into one pending flag.

## Structure
- Shared package holds:
  - the FSM state enum (ST_IDLE, ST_OFFER);
  - a function computing the round-robin winner from a flag vector and ptr.
- Sub-module flag_cell: one set/clear bit with asynchronous reset, instantiated NUM_FLAGS times via generate.
- Top level holds the FSM, ptr, and the selection logic.

## Test plan
- Reset and idle:
  - assert reset mid-cycle with flag 3 pending and rdValid = 1 → rdValid, rdIdx and anyPending go to 0 without waiting for clk;
  - after release, no offer appears.
- Basic latency:
  - pulse setIn = 8'b0000_0100 for one cycle with rdReady = 1 → rdValid rises 2 edges later with rdIdx = 2;
  - accepted on that edge, rdValid low the next cycle, anyPending 0.
- Round-robin fairness:
  - set flags 1, 5, 6 together and hold rdReady = 1 → indices read in order 1, 5, 6;
  - then set flags 0 and 6 → order 0, 6 (ptr = 7 wraps to 0 first).
- Stall:
  - flags 2 and 4 pending, rdReady = 0 for 10 cycles while setIn pulses flag 0 → rdIdx stays 2 throughout;
  - after release, order is 2, 4, 0.
- Set/clear collision:
  - pulse setIn[3] in the same cycle as acceptance of index 3 → flag 3 remains set and is offered again.
- Overflow, macro defined:
  - pulse setIn[7] twice while flag 7 is pending → overflowOut[7] = 1 and stays 1 after the read;
  - a single set followed by a read leaves overflowOut = 0.

Source files
------------

// File: rtl/flag_read_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : flag_read_arbiter_pkg
// Brief  : FSM state encoding and round-robin winner search for flag_read_arbiter.
// Rev    : 1.0
// ============================================================================
package flag_read_arbiter_pkg;

    localparam int c_MAX_FLAGS = 64;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    // First set flag at or after ptr, searching upward modulo n.
    // The loop runs downward so the lowest distance from ptr wins last.
    function automatic logic [5:0] rr_pick(input logic [c_MAX_FLAGS-1:0] flags,
                                           input logic [5:0]             ptr,
                                           input int                     n);
        logic [5:0] win;
        int         idx;
        win = ptr;
        for (int i = c_MAX_FLAGS - 1; i >= 0; i--) begin
            if (i < n) begin
                idx = (int'(ptr) + i) % n;
                if (flags[idx]) begin
                    win = 6'(idx);
                end
            end
        end
        return win;
    endfunction

endpackage
`default_nettype wire

// File: rtl/flag_read_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : flag_read_arbiter_if
// Brief  : Valid/ready read handshake carrying the offered flag index.
// Rev    : 1.0
// ============================================================================
interface flag_read_arbiter_if #(
    parameter int IDX_W = 3
);
    logic             rdValid;
    logic             rdReady;
    logic [IDX_W-1:0] rdIdx;

    modport master (output rdValid, output rdIdx, input rdReady);
    modport slave  (input rdValid, input rdIdx, output rdReady);
endinterface
`default_nettype wire

// File: rtl/flag_read_arbiter_flag_cell.sv
`default_nettype none
// ============================================================================
// Module : flag_cell
// Brief  : One set/clear flag bit; set has priority over clear.
// Rev    : 1.0
// ============================================================================
module flag_cell (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic set,
    input  wire logic clr,
    output logic      q
);
    logic r_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= 1'b0;
        end else begin
            r_q <= set | (r_q & ~clr);
        end
    end

    assign q = r_q;
endmodule
`default_nettype wire

// File: rtl/flag_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module : flag_read_arbiter
// Brief  : Read-and-clear flag bank offering one pending index at a time,
//          round-robin. FLAG_READ_ARBITER_OVERFLOW_EN adds sticky overflowOut.
// Rev    : 1.0
// ============================================================================
module flag_read_arbiter
    import flag_read_arbiter_pkg::*;
#(
    parameter int NUM_FLAGS = 8,
    parameter int IDX_W     = $clog2(NUM_FLAGS)
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    input  wire logic [NUM_FLAGS-1:0] setIn,
    flag_read_arbiter_if.master       rd,
    output logic                      anyPending
`ifdef FLAG_READ_ARBITER_OVERFLOW_EN
    ,
    output logic [NUM_FLAGS-1:0]      overflowOut
`endif
);
    state_t               r_state;
    state_t               w_state_nxt;
    logic [IDX_W-1:0]     r_idx;
    logic [IDX_W-1:0]     w_idx_nxt;
    logic [IDX_W-1:0]     r_ptr;
    logic [IDX_W-1:0]     w_ptr_nxt;
    logic [IDX_W-1:0]     w_pick;
    logic [NUM_FLAGS-1:0] w_flags;
    logic [NUM_FLAGS-1:0] w_clear;
    logic                 w_accept;

    assign w_accept = (r_state == ST_OFFER) && rd.rdReady;

    always_comb begin
        w_clear = '0;
        if (w_accept) begin
            w_clear[r_idx] = 1'b1;
        end
    end

    generate
        for (genvar i = 0; i < NUM_FLAGS; i++) begin : g_flag
            flag_cell u_cell (
                .clk   (clk),
                .reset (reset),
                .set   (setIn[i]),
                .clr   (w_clear[i]),
                .q     (w_flags[i])
            );
        end
    endgenerate

    assign w_pick = IDX_W'(rr_pick(64'(w_flags), 6'(r_ptr), NUM_FLAGS));

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (|w_flags) begin
                    w_state_nxt = ST_OFFER;
                    w_idx_nxt   = w_pick;
                end
            end
            ST_OFFER: begin
                if (rd.rdReady) begin
                    w_state_nxt = ST_IDLE;
                    w_ptr_nxt   = (r_idx == IDX_W'(NUM_FLAGS - 1)) ? '0 : r_idx + 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    assign rd.rdValid = (r_state == ST_OFFER);
    assign rd.rdIdx   = r_idx;
    assign anyPending = |w_flags;

`ifdef FLAG_READ_ARBITER_OVERFLOW_EN
    logic [NUM_FLAGS-1:0] r_ovf;

    // A set landing on a flag that survives this cycle would be merged away.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf <= '0;
        end else begin
            r_ovf <= r_ovf | (setIn & w_flags & ~w_clear);
        end
    end

    assign overflowOut = r_ovf;
`endif
endmodule
`default_nettype wire

// File: tb/tb_flag_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_flag_read_arbiter
// Brief  : Scoreboard bench: expected read indices queued, monitor compares.
// Rev    : 1.0
// ============================================================================
module tb_flag_read_arbiter;
    logic       clk;
    logic       reset;
    logic [7:0] setIn;
    logic       anyPending;
`ifdef FLAG_READ_ARBITER_OVERFLOW_EN
    logic [7:0] overflowOut;
`endif

    int n_pass  = 0;
    int n_total = 0;
    int exp_q[$];

    flag_read_arbiter_if #(.IDX_W(3)) rd();

    flag_read_arbiter #(.NUM_FLAGS(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .setIn       (setIn),
        .rd          (rd),
        .anyPending  (anyPending)
`ifdef FLAG_READ_ARBITER_OVERFLOW_EN
        ,
        .overflowOut (overflowOut)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor: every completed handshake must match the head of the queue.
    always @(negedge clk) begin
        if (!reset && rd.rdValid && rd.rdReady) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_read: got idx %0d expected none", rd.rdIdx);
            end else begin
                check("read_idx", int'(rd.rdIdx), exp_q.pop_front());
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        #3;
        reset = 1'b0;
    endtask

    task automatic pulse_set(input logic [7:0] mask);
        @(posedge clk); #1;
        setIn = mask;
        @(posedge clk); #1;
        setIn = '0;
    endtask

    task automatic wait_valid(input string name);
        int k;
        k = 0;
        while (!rd.rdValid && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        if (!rd.rdValid) check(name, 0, 1);
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || rd.rdValid) && k < 60) begin
            @(posedge clk); #1;
            k++;
        end
        if (exp_q.size() != 0 || rd.rdValid) check(name, exp_q.size(), 0);
    endtask

    initial begin
        reset      = 1'b1;
        setIn      = '0;
        rd.rdReady = 1'b0;
        #12;
        check("reset_valid", int'(rd.rdValid), 0);
        check("reset_idx", int'(rd.rdIdx), 0);
        check("reset_pending", int'(anyPending), 0);
        reset = 1'b0;

        // Reset mid-offer, asynchronously
        pulse_set(8'b0000_1000);
        wait_valid("offer3_timeout");
        check("offer3_idx", int'(rd.rdIdx), 3);
        #2 reset = 1'b1;
        #1;
        check("async_valid", int'(rd.rdValid), 0);
        check("async_idx", int'(rd.rdIdx), 0);
        check("async_pending", int'(anyPending), 0);
        #1 reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("post_reset_valid", int'(rd.rdValid), 0);

        // Basic latency
        @(posedge clk); #1;
        setIn = 8'b0000_0100;
        rd.rdReady = 1'b1;
        exp_q.push_back(2);
        @(posedge clk); #1;
        setIn = '0;
        check("lat_pending", int'(anyPending), 1);
        check("lat_valid_early", int'(rd.rdValid), 0);
        @(posedge clk); #1;
        check("lat_valid", int'(rd.rdValid), 1);
        check("lat_idx", int'(rd.rdIdx), 2);
        @(posedge clk); #1;
        check("lat_valid_after", int'(rd.rdValid), 0);
        check("lat_pending_after", int'(anyPending), 0);

        // Round-robin fairness with wrap
        do_reset();
        exp_q.push_back(1); exp_q.push_back(5); exp_q.push_back(6);
        pulse_set(8'b0110_0010);
        wait_drain("rr1_drain");
        exp_q.push_back(0); exp_q.push_back(6);
        pulse_set(8'b0100_0001);
        wait_drain("rr2_drain");

        // Stall with a late set
        do_reset();
        rd.rdReady = 1'b0;
        exp_q.push_back(2); exp_q.push_back(4); exp_q.push_back(0);
        pulse_set(8'b0001_0100);
        wait_valid("stall_timeout");
        for (int c = 0; c < 10; c++) begin
            if (c == 2) setIn = 8'b0000_0001;
            if (c == 3) setIn = '0;
            check("stall_idx", int'(rd.rdIdx), 2);
            @(posedge clk); #1;
        end
        check("stall_valid", int'(rd.rdValid), 1);
        rd.rdReady = 1'b1;
        wait_drain("stall_drain");

        // Set and clear collide on the same flag
        do_reset();
        rd.rdReady = 1'b0;
        exp_q.push_back(3); exp_q.push_back(3);
        pulse_set(8'b0000_1000);
        wait_valid("coll_timeout");
        rd.rdReady = 1'b1;
        setIn = 8'b0000_1000;
        @(posedge clk); #1;
        setIn = '0;
        check("coll_pending", int'(anyPending), 1);
        wait_drain("coll_drain");
        check("coll_pending_after", int'(anyPending), 0);

`ifdef FLAG_READ_ARBITER_OVERFLOW_EN
        do_reset();
        rd.rdReady = 1'b0;
        exp_q.push_back(7);
        pulse_set(8'b1000_0000);
        wait_valid("ovf_timeout");
        check("ovf_before", int'(overflowOut), 0);
        pulse_set(8'b1000_0000);
        check("ovf_set", int'(overflowOut), 8'h80);
        rd.rdReady = 1'b1;
        wait_drain("ovf_drain");
        check("ovf_sticky", int'(overflowOut), 8'h80);
        do_reset();
        exp_q.push_back(7);
        pulse_set(8'b1000_0000);
        wait_drain("ovf1_drain");
        check("ovf_single", int'(overflowOut), 0);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
